sync_read_mem: RTL
==================

// Module: sync_read_mem
//
// PURPOSE
//   Byte-addressed, word-organised scratchpad with registered reads.
//   Two masked write ports: hw (host/loader) and dw (core data).
//   NUM_RD independent pipelined read ports for core data and instruction fetch.
//   After every reset a sequential init engine zeroes the whole array.
//   Next generation of the async-read memory: synchronous, with configurable latency, port count and depth.
//
// PARAMETERS
//   DATA_WIDTH   32    word width in bits; multiple of 8; MASK_WIDTH = DATA_WIDTH/8
//   DEPTH_WORDS  1024  number of words; power of 2; byte span = DEPTH_WORDS*MASK_WIDTH
//   NUM_RD       2     number of read ports, 1..4
//   RD_LATENCY   1     cycles from rd_req to rd_valid, 1..3
//
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   reset_n    in   1                  asynchronous, active-low reset
//   init_done  out  1                  high once array is zeroed; stays high until next reset
//   hw_en      in   1                  host write strobe
//   hw_addr    in   32                 host byte address
//   hw_data    in   DATA_WIDTH         host write data
//   hw_mask    in   MASK_WIDTH         host byte enables; bit i -> byte i
//   dw_en      in   1                  data write strobe
//   dw_addr    in   32                 data byte address
//   dw_data    in   DATA_WIDTH         data write data
//   dw_mask    in   MASK_WIDTH         data byte enables
//   rd_req     in   NUM_RD             per-port read request
//   rd_addr    in   NUM_RD*32          per-port byte address; port p = [p*32 +: 32]
//   rd_valid   out  NUM_RD             per-port read-data valid, one-cycle pulse per request
//   rd_data    out  NUM_RD*DATA_WIDTH  per-port read data
//   rd_err     out  NUM_RD             per-port out-of-range flag, qualified by rd_valid
//
// BEHAVIOUR
//   - Reset (async assert): FSM -> INIT, init pointer = 0.
//     Reset values: init_done=0, rd_valid=0, rd_data=0, rd_err=0.
//     All read pipeline stages are cleared.
//   - FSM INIT:
//     - writes word[ptr]=0 each cycle; ptr increments by 1.
//     - at ptr==DEPTH_WORDS-1 moves to READY; init takes exactly DEPTH_WORDS cycles.
//     - hw/dw writes and rd_req are ignored: dropped, no rd_valid.
//   - FSM READY:
//     - init_done=1; the FSM stays in READY until reset.
//     - Reset mid-init or mid-read restarts INIT and drops any in-flight reads.
//   - Address decode:
//     - word index = addr[log2(MASK_WIDTH) +: log2(DEPTH_WORDS)].
//     - Low log2(MASK_WIDTH) bits are ignored (truncated, not an error).
//     - Out of range when addr >= DEPTH_WORDS*MASK_WIDTH.
//   - Writes (READY), committed at the rising edge of the cycle en is high:
//     - bytes with mask=0 are unchanged.
//     - Both ports, same word: bytes are merged; hw wins where both masks are set.
//     - Out-of-range writes are dropped silently.
//   - Reads (READY):
//     - rd_req in cycle T -> rd_valid=1 in T+RD_LATENCY, with rd_data = word at edge T.
//     - Fully pipelined: one request per port per cycle, no stalls, no backpressure.
//     - Ports are independent; the same word on all ports is legal.
//     - Out-of-range read: rd_data=0, rd_err=1 at the same latency.
//     - rd_data holds its last value while rd_valid=0.
//   - Read/write collision, same word in the same cycle: read returns OLD contents (see macro).
//
// CONFIGURATION
//   SYNC_READ_MEM_BYPASS_EN
//   - Defined: a read colliding with a same-cycle write returns the post-write merged word
//     (hw/dw priority applied; unmasked bytes keep old values). Latency is unchanged.
//   - Undefined: read-old-data semantics as above, with no bypass muxing.
//
// TESTING
//   - Init: release reset_n; no write/read for DEPTH_WORDS cycles
//     -> init_done rises exactly DEPTH_WORDS cycles later; every word reads 0.
//   - Masked write: dw 0x10 data 0xAABBCCDD mask 4'b0101, RD_LATENCY=2; rd port0 0x10
//     -> rd_valid 2 cycles after rd_req, data 0x00BB00DD, rd_err=0.
//   - Collision: same cycle hw 0x20 0x11111111 mask 4'b0011, dw 0x20 0x22222222 mask 4'b0110
//     -> word 0x20 = 0x00221111.
//   - Range: rd port1 addr DEPTH_WORDS*4; dw same addr
//     -> rd_valid=1, rd_err=1, rd_data=0; no word modified.
//   - Back-to-back: port0 reads 0x0,0x4,0x8 and port1 reads 0x8,0x4,0x0 on consecutive cycles
//     -> both ports return 3 consecutive valids in order.
//   - Bypass: write 0x30=0xDEADBEEF mask 4'hF with rd 0x30 in the same cycle
//     -> 0xDEADBEEF with the macro, prior value without it.
//     Also: assert reset_n mid-read -> no rd_valid, INIT restarts.

Source files
------------

// File: rtl/sync_read_mem.sv
// sync_read_mem: byte-addressed scratchpad with two masked write ports (hw over dw),
// NUM_RD pipelined read ports and a post-reset zeroing engine. Macro: SYNC_READ_MEM_BYPASS_EN.
module sync_read_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int NUM_RD      = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         init_done,
  output logic                         dbg_state,
  input  logic                         hw_en,
  input  logic [31:0]                  hw_addr,
  input  logic [DATA_WIDTH-1:0]        hw_data,
  input  logic [DATA_WIDTH/8-1:0]      hw_mask,
  input  logic                         dw_en,
  input  logic [31:0]                  dw_addr,
  input  logic [DATA_WIDTH-1:0]        dw_data,
  input  logic [DATA_WIDTH/8-1:0]      dw_mask,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*32-1:0]         rd_addr,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_err
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_BITS  = $clog2(MASK_WIDTH);
  localparam int IDX_BITS   = $clog2(DEPTH_WORDS);
  localparam int SPAN_BITS  = BYTE_BITS + IDX_BITS;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_BITS-1:0]   r_ptr;
  logic [IDX_BITS-1:0]   w_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic                  w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_INIT: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == IDX_BITS'(DEPTH_WORDS - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        w_state_nxt = ST_READY;
      end
    endcase
  end

  assign w_ready   = (r_state == ST_READY);
  assign init_done = w_ready;
  assign dbg_state = r_state;

  // Write decode: an address beyond the byte span disables the port entirely.
  logic [IDX_BITS-1:0] w_hw_idx;
  logic [IDX_BITS-1:0] w_dw_idx;
  logic                w_hw_we;
  logic                w_dw_we;

  assign w_hw_idx = hw_addr[BYTE_BITS +: IDX_BITS];
  assign w_dw_idx = dw_addr[BYTE_BITS +: IDX_BITS];
  assign w_hw_we  = w_ready && hw_en && ((hw_addr >> SPAN_BITS) == 32'd0);
  assign w_dw_we  = w_ready && dw_en && ((dw_addr >> SPAN_BITS) == 32'd0);

  // dw lanes are issued first so a same-byte hw lane overrides them.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= '0;
    end else begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (w_dw_we && dw_mask[b]) begin
          r_mem[w_dw_idx][b*8 +: 8] <= dw_data[b*8 +: 8];
        end
        if (w_hw_we && hw_mask[b]) begin
          r_mem[w_hw_idx][b*8 +: 8] <= hw_data[b*8 +: 8];
        end
      end
    end
  end

  logic [NUM_RD-1:0]            w_rd_v;
  logic [NUM_RD-1:0]            w_rd_oor;
  logic [NUM_RD*DATA_WIDTH-1:0] w_rd_flat;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [31:0]           w_addr;
    logic [IDX_BITS-1:0]   w_idx;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_addr      = rd_addr[p*32 +: 32];
    assign w_idx       = w_addr[BYTE_BITS +: IDX_BITS];
    assign w_rd_oor[p] = ((w_addr >> SPAN_BITS) != 32'd0);
    assign w_rd_v[p]   = w_ready && rd_req[p];

    always_comb begin
      w_word = r_mem[w_idx];
`ifdef SYNC_READ_MEM_BYPASS_EN
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (w_dw_we && dw_mask[b] && (w_dw_idx == w_idx)) begin
          w_word[b*8 +: 8] = dw_data[b*8 +: 8];
        end
        if (w_hw_we && hw_mask[b] && (w_hw_idx == w_idx)) begin
          w_word[b*8 +: 8] = hw_data[b*8 +: 8];
        end
      end
`endif
    end

    assign w_rd_flat[p*DATA_WIDTH +: DATA_WIDTH] = w_rd_oor[p] ? '0 : w_word;
  end

  // Read pipeline: data/err lanes only load with their valid, so the output holds between reads.
  logic [NUM_RD-1:0]            r_pv [RD_LATENCY];
  logic [NUM_RD*DATA_WIDTH-1:0] r_pd [RD_LATENCY];
  logic [NUM_RD-1:0]            r_pe [RD_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_pv[s] <= '0;
        r_pd[s] <= '0;
        r_pe[s] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_v;
      for (int p = 0; p < NUM_RD; p++) begin
        if (w_rd_v[p]) begin
          r_pd[0][p*DATA_WIDTH +: DATA_WIDTH] <= w_rd_flat[p*DATA_WIDTH +: DATA_WIDTH];
          r_pe[0][p]                          <= w_rd_oor[p];
        end
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pv[s] <= r_pv[s-1];
        for (int p = 0; p < NUM_RD; p++) begin
          if (r_pv[s-1][p]) begin
            r_pd[s][p*DATA_WIDTH +: DATA_WIDTH] <= r_pd[s-1][p*DATA_WIDTH +: DATA_WIDTH];
            r_pe[s][p]                          <= r_pe[s-1][p];
          end
        end
      end
    end
  end

  assign rd_valid = r_pv[RD_LATENCY-1];
  assign rd_data  = r_pd[RD_LATENCY-1];
  assign rd_err   = r_pe[RD_LATENCY-1];

endmodule
